bp_me_mem_port_mux: RTL and testbench

//  N-channel memory-port multiplexer: lets num_ch_p cache/FE engines share one bp_mem-style port.

---
 rtl/bp_me_pkg.sv | 14 +
 rtl/bp_me_mem_port_rr_arb.sv | 38 +++
 rtl/bp_me_mem_port_mux.sv | 125 ++++++++++++
 tb/tb_bp_me_mem_port_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the memory-port multiplexer.
package bp_me_pkg;

    typedef enum logic {
        e_arb_rr    = 1'b0,
        e_arb_fixed = 1'b1
    } bp_me_arb_mode_e;

    // Channel-id width; a single channel still carries a 1-bit tag.
    function automatic int tag_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/bp_me_mem_port_rr_arb.sv
// Channel arbiter: picks one valid channel, either round-robin from ptr_i or lowest index first.
module bp_me_mem_port_rr_arb
    import bp_me_pkg::*;
#(
    parameter int              num_ch_p   = 2,
    parameter bp_me_arb_mode_e arb_mode_p = e_arb_rr,
    localparam int             tag_w_lp   = tag_width(num_ch_p)
) (
    input  logic [num_ch_p-1:0] v_i,
    input  logic [tag_w_lp-1:0] ptr_i,
    output logic [num_ch_p-1:0] grant_oh_o,
    output logic [tag_w_lp-1:0] grant_id_o,
    output logic                grant_v_o
);

    // Walk the channels in priority order and take the first valid one.
    always_comb begin
        int   idx;
        logic found;
        grant_oh_o = '0;
        grant_id_o = '0;
        found      = 1'b0;
        for (int k = 0; k < num_ch_p; k++) begin
            if (arb_mode_p == e_arb_fixed) begin
                idx = k;
            end else begin
                idx = (int'(ptr_i) + k) % num_ch_p;
            end
            if (!found && v_i[idx]) begin
                found           = 1'b1;
                grant_id_o      = tag_w_lp'(idx);
                grant_oh_o[idx] = 1'b1;
            end
        end
        grant_v_o = found;
    end

endmodule

// File: rtl/bp_me_mem_port_mux.sv
// N-channel memory-port mux: arbitrates commands onto one port and routes in-order responses back
// to the issuing channel using a tag FIFO of channel ids.
module bp_me_mem_port_mux
    import bp_me_pkg::*;
#(
    parameter int              mem_msg_width_p   = 16,
    parameter int              num_ch_p          = 2,
    parameter int              max_outstanding_p = 8,
    parameter bp_me_arb_mode_e arb_mode_p        = e_arb_rr,
    localparam int             cnt_w_lp          = $clog2(max_outstanding_p) + 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_ch_p*mem_msg_width_p-1:0]   ch_cmd_i,
    input  logic [num_ch_p-1:0]                   ch_cmd_v_i,
    output logic [num_ch_p-1:0]                   ch_cmd_ready_o,
    output logic [mem_msg_width_p-1:0]            ch_resp_o,
    output logic [num_ch_p-1:0]                   ch_resp_v_o,
    input  logic [num_ch_p-1:0]                   ch_resp_yumi_i,
    output logic [mem_msg_width_p-1:0]            mem_cmd_o,
    output logic                                  mem_cmd_v_o,
    input  logic                                  mem_cmd_ready_i,
    input  logic [mem_msg_width_p-1:0]            mem_resp_i,
    input  logic                                  mem_resp_v_i,
    output logic                                  mem_resp_yumi_o,
    output logic [cnt_w_lp-1:0]                   outstanding_o,
    output logic                                  err_o
);

    localparam int tag_w_lp = tag_width(num_ch_p);
    localparam int aw_lp    = $clog2(max_outstanding_p);

    logic [tag_w_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [tag_w_lp-1:0] tags_q [max_outstanding_p];
    logic [tag_w_lp-1:0] tags_d [max_outstanding_p];
    logic [aw_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [num_ch_p-1:0] grant_oh, head_oh;
    logic [tag_w_lp-1:0] grant_id, head;
    logic                grant_v, fifo_full, fifo_empty, push, pop, resp_live;

    bp_me_mem_port_rr_arb #(
        .num_ch_p   (num_ch_p),
        .arb_mode_p (arb_mode_p)
    ) u_arb (
        .v_i        (ch_cmd_v_i),
        .ptr_i      (rr_ptr_q),
        .grant_oh_o (grant_oh),
        .grant_id_o (grant_id),
        .grant_v_o  (grant_v)
    );

    // Command path: granted channel drives the memory port; full FIFO blocks everything (no bypass).
    always_comb begin
        fifo_full      = (cnt_q == cnt_w_lp'(max_outstanding_p));
        fifo_empty     = (cnt_q == '0);
        mem_cmd_o      = ch_cmd_i[int'(grant_id)*mem_msg_width_p +: mem_msg_width_p];
        mem_cmd_v_o    = ~reset_i & grant_v & ~fifo_full;
        ch_cmd_ready_o = (reset_i || fifo_full || !mem_cmd_ready_i) ? '0 : grant_oh;
        push           = mem_cmd_v_o & mem_cmd_ready_i;
    end

    // Response path: head tag selects the owner; memory is only acknowledged when the owner consumes.
    always_comb begin
        head    = tags_q[rd_ptr_q];
        head_oh = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            head_oh[i] = (head == tag_w_lp'(i));
        end
        resp_live       = ~reset_i & mem_resp_v_i & ~fifo_empty;
        ch_resp_o       = mem_resp_i;
        ch_resp_v_o     = resp_live ? head_oh : '0;
        mem_resp_yumi_o = resp_live & |(ch_resp_yumi_i & head_oh);
        pop             = mem_resp_yumi_o;
    end

    // Next-state for tag FIFO, round-robin pointer and the sticky stray-response flag.
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q | (mem_resp_v_i & fifo_empty);
        if (push) begin
            tags_d[wr_ptr_q] = grant_id;
            wr_ptr_d         = wr_ptr_q + aw_lp'(1);
            if (arb_mode_p == e_arb_rr) begin
                rr_ptr_d = (grant_id == tag_w_lp'(num_ch_p - 1)) ? '0 : grant_id + tag_w_lp'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + aw_lp'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; tag storage needs no reset because the count gates every read.
    always_ff @(posedge clk_i) begin
        tags_q <= tags_d;
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bp_me_mem_port_mux.sv
// Directed bench: a 2-channel round-robin mux (depth 4) and a 3-channel fixed-priority mux (depth 8).
module tb_bp_me_mem_port_mux;
    import bp_me_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Round-robin instance
    logic          a_rst;
    logic [2*W-1:0] a_cmd;
    logic [1:0]    a_cmd_v, a_rdy, a_resp_v, a_yumi;
    logic [W-1:0]  a_resp, a_mcmd, a_mresp;
    logic          a_mcmd_v, a_mrdy, a_mresp_v, a_myumi, a_err;
    logic [2:0]    a_out;

    bp_me_mem_port_mux #(
        .mem_msg_width_p(W), .num_ch_p(2), .max_outstanding_p(4), .arb_mode_p(e_arb_rr)
    ) dut_a (
        .clk_i(clk), .reset_i(a_rst),
        .ch_cmd_i(a_cmd), .ch_cmd_v_i(a_cmd_v), .ch_cmd_ready_o(a_rdy),
        .ch_resp_o(a_resp), .ch_resp_v_o(a_resp_v), .ch_resp_yumi_i(a_yumi),
        .mem_cmd_o(a_mcmd), .mem_cmd_v_o(a_mcmd_v), .mem_cmd_ready_i(a_mrdy),
        .mem_resp_i(a_mresp), .mem_resp_v_i(a_mresp_v), .mem_resp_yumi_o(a_myumi),
        .outstanding_o(a_out), .err_o(a_err)
    );

    // Fixed-priority instance
    logic          b_rst;
    logic [3*W-1:0] b_cmd;
    logic [2:0]    b_cmd_v, b_rdy, b_resp_v, b_yumi;
    logic [W-1:0]  b_resp, b_mcmd, b_mresp;
    logic          b_mcmd_v, b_mrdy, b_mresp_v, b_myumi, b_err;
    logic [3:0]    b_out;

    bp_me_mem_port_mux #(
        .mem_msg_width_p(W), .num_ch_p(3), .max_outstanding_p(8), .arb_mode_p(e_arb_fixed)
    ) dut_b (
        .clk_i(clk), .reset_i(b_rst),
        .ch_cmd_i(b_cmd), .ch_cmd_v_i(b_cmd_v), .ch_cmd_ready_o(b_rdy),
        .ch_resp_o(b_resp), .ch_resp_v_o(b_resp_v), .ch_resp_yumi_i(b_yumi),
        .mem_cmd_o(b_mcmd), .mem_cmd_v_o(b_mcmd_v), .mem_cmd_ready_i(b_mrdy),
        .mem_resp_i(b_mresp), .mem_resp_v_i(b_mresp_v), .mem_resp_yumi_o(b_myumi),
        .outstanding_o(b_out), .err_o(b_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_cmd = {16'h00B1, 16'h00A0}; a_cmd_v = 2'b11; a_yumi = 2'b00;
        a_mrdy = 1'b1; a_mresp = 16'h1234; a_mresp_v = 1'b1;
        b_rst = 1'b1; b_cmd = {16'h00C2, 16'h00C1, 16'h00C0}; b_cmd_v = 3'b000; b_yumi = 3'b000;
        b_mrdy = 1'b0; b_mresp = 16'h5678; b_mresp_v = 1'b0;

        // Reset: every valid/ready/yumi output held low even with live inputs
        tick(); tick();
        chk("rst_mcmd_v", 64'(a_mcmd_v), 64'd0);
        chk("rst_ready", 64'(a_rdy), 64'd0);
        chk("rst_resp_v", 64'(a_resp_v), 64'd0);
        chk("rst_myumi", 64'(a_myumi), 64'd0);
        a_mresp_v = 1'b0;
        a_rst = 1'b0;
        #1;
        chk("rst_out", 64'(a_out), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);

        // Round-robin alternation with both channels valid, filling the depth-4 FIFO
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", 64'(a_rdy), (k % 2 == 1) ? 64'h2 : 64'h1);
            chk("rr_mcmd", 64'(a_mcmd), (k % 2 == 1) ? 64'h00B1 : 64'h00A0);
            chk("rr_out", 64'(a_out), 64'(k));
            tick();
        end
        chk("full_out", 64'(a_out), 64'd4);
        chk("full_ready", 64'(a_rdy), 64'd0);
        chk("full_mcmd_v", 64'(a_mcmd_v), 64'd0);

        // Owner (ch0) withholds consume for 3 cycles; ch1's yumi must not pop
        a_mresp_v = 1'b1; a_yumi = 2'b10;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("hold_resp_v", 64'(a_resp_v), 64'h1);
            chk("hold_myumi", 64'(a_myumi), 64'd0);
            chk("hold_out", 64'(a_out), 64'd4);
            tick();
        end

        // Pop while full: ready stays low this cycle, slot usable next cycle
        a_yumi = 2'b11;
        #1;
        chk("pop_myumi", 64'(a_myumi), 64'd1);
        chk("pop_resp", 64'(a_resp), 64'h1234);
        chk("pop_nobypass", 64'(a_rdy), 64'd0);
        tick();
        a_mresp_v = 1'b0;
        #1;
        chk("pop_out", 64'(a_out), 64'd3);
        chk("pop_ready", 64'(a_rdy), 64'h1);
        tick();

        // Drain: FIFO holds owners 1,0,1,0
        a_cmd_v = 2'b00; a_mresp_v = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_resp_v", 64'(a_resp_v), (k % 2 == 0) ? 64'h2 : 64'h1);
            tick();
        end
        chk("drain_out", 64'(a_out), 64'd0);

        // Stray response with empty FIFO
        chk("stray_resp_v", 64'(a_resp_v), 64'd0);
        chk("stray_myumi", 64'(a_myumi), 64'd0);
        chk("stray_err_pre", 64'(a_err), 64'd0);
        tick();
        chk("stray_err", 64'(a_err), 64'd1);
        a_mresp_v = 1'b0;
        tick();
        chk("stray_err_hold", 64'(a_err), 64'd1);

        // Mid-operation reset with 3 outstanding (ptr left at 1)
        a_cmd_v = 2'b01;
        tick(); tick(); tick();
        chk("pre_rst_out", 64'(a_out), 64'd3);
        a_cmd_v = 2'b00; a_rst = 1'b1;
        #1;
        tick();
        a_rst = 1'b0; a_cmd_v = 2'b11;
        #1;
        chk("mid_rst_out", 64'(a_out), 64'd0);
        chk("mid_rst_err", 64'(a_err), 64'd0);
        chk("mid_rst_ptr", 64'(a_rdy), 64'h1);
        tick();
        chk("mid_rst_accept", 64'(a_out), 64'd1);
        a_cmd_v = 2'b00;

        // Fixed priority: ch0 held while valid, then ch1
        b_rst = 1'b0; b_cmd_v = 3'b111; b_mrdy = 1'b1; b_yumi = 3'b111;
        #1;
        chk("fx_ready0", 64'(b_rdy), 64'h1);
        chk("fx_mcmd0", 64'(b_mcmd), 64'h00C0);
        tick();
        b_mresp_v = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("fx_ready", 64'(b_rdy), 64'h1);
            chk("fx_resp_v", 64'(b_resp_v), 64'h1);
            tick();
        end
        b_cmd_v = 3'b110;
        #1;
        chk("fx_ready1", 64'(b_rdy), 64'h2);
        chk("fx_mcmd1", 64'(b_mcmd), 64'h00C1);
        chk("fx_resp_v0", 64'(b_resp_v), 64'h1);
        tick();
        chk("fx_resp_v1", 64'(b_resp_v), 64'h2);
        chk("fx_out", 64'(b_out), 64'd1);
        chk("fx_err", 64'(b_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
